// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: the write port, the read port, occupancy and error flags.
// The master side drives requests; the slave side (the FIFO) drives status and data.
interface sync_fifo_param_if #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 9
) ();
    logic                 wr;
    logic [WIDTH-1:0]     wr_data;
    logic                 not_full;
    logic                 rd;
    logic [WIDTH-1:0]     rd_data;
    logic                 not_empty;
    logic [ADDR_BITS:0]   count;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 overflow;
    logic                 underflow;
    logic                 err_clr;

    modport master (
        output wr, wr_data, rd, err_clr,
        input  not_full, rd_data, not_empty, count,
        input  almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr, wr_data, rd, err_clr,
        output not_full, rd_data, not_empty, count,
        output almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with active-low wr/rd requests, registered status flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise reads have one-edge latency.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 9,
    parameter int AF_LEVEL  = 480,
    parameter int AE_LEVEL  = 32
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave bus
);
    localparam int              CW      = ADDR_BITS + 1;
    localparam int              DEPTH   = 2 ** ADDR_BITS;
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]   AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_not_full;
    logic             r_not_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CW-1:0]    w_count_next;

    // Acceptance is decided from the registered flags seen before the edge.
    assign w_wr_acc = ~rst & ~bus.wr & r_not_full;
    assign w_rd_acc = ~rst & ~bus.rd & r_not_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_next = r_count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_not_full     <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            r_count        <= w_count_next;
            r_not_full     <= (w_count_next != DEPTH_C);
            r_almost_full  <= (w_count_next >= AF_C);
            r_almost_empty <= (w_count_next <= AE_C);
            // A new error on the same edge as err_clr stays visible.
            if (!bus.wr && !r_not_full) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (!bus.rd && !r_not_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifndef SYNC_FIFO_FWFT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_rd_data   <= '0;
            r_not_empty <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + ONE;
                r_rd_data <= r_mem[r_rd_ptr[ADDR_BITS-1:0]];
            end
            r_not_empty <= (w_count_next != '0);
        end
    end
`else
    // Two-stage output: r_pf_* holds the word fetched from memory, r_rd_data is the visible head.
    logic [WIDTH-1:0] r_pf_data;
    logic             r_pf_valid;
    logic             w_out_load;
    logic             w_pf_free;
    logic             w_mem_avail;

    assign w_out_load  = ~r_not_empty | w_rd_acc;
    assign w_pf_free   = ~r_pf_valid | w_out_load;
    assign w_mem_avail = (r_wr_ptr != r_rd_ptr);

    always_ff @(posedge clk) begin
        if (w_pf_free && w_mem_avail) begin
            r_pf_data <= r_mem[r_rd_ptr[ADDR_BITS-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_pf_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_not_empty <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_not_empty <= r_pf_valid;
                if (r_pf_valid) begin
                    r_rd_data <= r_pf_data;
                end
            end
            if (w_pf_free) begin
                r_pf_valid <= w_mem_avail;
                if (w_mem_avail) begin
                    r_rd_ptr <= r_rd_ptr + ONE;
                end
            end
        end
    end
`endif

    assign bus.count        = r_count;
    assign bus.not_full     = r_not_full;
    assign bus.not_empty    = r_not_empty;
    assign bus.rd_data      = r_rd_data;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=8, ADDR_BITS=4, AF_LEVEL=14, AE_LEVEL=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sync_fifo_param;
    localparam int WIDTH     = 8;
    localparam int ADDR_BITS = 4;
    localparam int AF_LEVEL  = 14;
    localparam int AE_LEVEL  = 2;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    sync_fifo_param_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .ADDR_BITS(ADDR_BITS),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given request levels; prints one line per transaction.
    task automatic op(input logic wr_n, input logic rd_n, input logic [7:0] din, input logic clr);
        bus.wr      = wr_n;
        bus.rd      = rd_n;
        bus.wr_data = din;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        $display("[TB] rst=%b wr=%b rd=%b din=%02h clr=%b -> count=%0d dout=%02h ne=%b nf=%b ovf=%b unf=%b",
                 rst, wr_n, rd_n, din, clr, bus.count, bus.rd_data, bus.not_empty,
                 bus.not_full, bus.overflow, bus.underflow);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(bus.count), 0);
        check({tag, "_not_empty"}, 32'(bus.not_empty), 0);
        check({tag, "_not_full"}, 32'(bus.not_full), 1);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 0);
        check({tag, "_almost_empty"}, 32'(bus.almost_empty), 1);
        check({tag, "_almost_full"}, 32'(bus.almost_full), 0);
        check({tag, "_overflow"}, 32'(bus.overflow), 0);
        check({tag, "_underflow"}, 32'(bus.underflow), 0);
    endtask

    initial begin
        rst = 1'b1;
        op(1, 1, 8'h00, 0);
        op(0, 0, 8'hEE, 0);
        check_reset_state("reset");
        rst = 1'b0;

`ifndef SYNC_FIFO_FWFT_EN
        // Fill to full, then one write too many.
        for (int i = 1; i <= 16; i++) begin
            op(0, 1, 8'(i), 0);
            check("fill_count", 32'(bus.count), 32'(i));
            check("fill_almost_full", 32'(bus.almost_full), (i >= 14) ? 32'd1 : 32'd0);
            check("fill_almost_empty", 32'(bus.almost_empty), (i <= 2) ? 32'd1 : 32'd0);
            check("fill_not_full", 32'(bus.not_full), (i < 16) ? 32'd1 : 32'd0);
            check("fill_not_empty", 32'(bus.not_empty), 1);
        end
        op(0, 1, 8'h11, 0);
        check("ovf_set", 32'(bus.overflow), 1);
        check("ovf_count", 32'(bus.count), 16);
        op(1, 1, 8'h00, 1);
        check("ovf_clr", 32'(bus.overflow), 0);

        // Drain: data must come out 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            op(1, 0, 8'h00, 0);
            check("drain_data", 32'(bus.rd_data), 32'(i));
            check("drain_count", 32'(bus.count), 32'(16 - i));
        end
        check("drain_not_empty", 32'(bus.not_empty), 0);
        check("drain_almost_empty", 32'(bus.almost_empty), 1);
        op(1, 0, 8'h00, 0);
        check("unf_set", 32'(bus.underflow), 1);
        check("unf_rd_data_hold", 32'(bus.rd_data), 32'h10);
        check("unf_count", 32'(bus.count), 0);
        op(1, 0, 8'h00, 1);
        check("unf_set_beats_clr", 32'(bus.underflow), 1);
        op(1, 1, 8'h00, 1);
        check("unf_clr", 32'(bus.underflow), 0);

        // Occupancy 8, simultaneous read+write across the pointer wrap.
        for (int i = 0; i < 8; i++) op(0, 1, 8'(8'h20 + i), 0);
        check("mid_count", 32'(bus.count), 8);
        for (int k = 0; k < 20; k++) begin
            op(0, 0, 8'(8'h28 + k), 0);
            check("both_count", 32'(bus.count), 8);
            check("both_data", 32'(bus.rd_data), 32'(8'h20 + k));
        end
        for (int k = 0; k < 8; k++) begin
            op(1, 0, 8'h00, 0);
            check("wrap_drain_data", 32'(bus.rd_data), 32'(8'h34 + k));
        end
        check("wrap_drain_count", 32'(bus.count), 0);

        // Empty with both requests: write only, read rejected.
        op(0, 0, 8'hA5, 0);
        check("empty_both_count", 32'(bus.count), 1);
        check("empty_both_unf", 32'(bus.underflow), 1);
        check("empty_both_rd_data", 32'(bus.rd_data), 32'h3B);
        op(1, 1, 8'h00, 1);
        check("empty_both_clr", 32'(bus.underflow), 0);
        op(1, 0, 8'h00, 0);
        check("empty_both_read", 32'(bus.rd_data), 32'hA5);
        op(1, 0, 8'h00, 0);
        check("pre_rst_unf", 32'(bus.underflow), 1);

        // Reset mid-operation with a pending write that must be ignored.
        for (int i = 0; i < 5; i++) op(0, 1, 8'(8'h50 + i), 0);
        check("pre_rst_count", 32'(bus.count), 5);
        rst = 1'b1;
        op(0, 1, 8'h99, 0);
        rst = 1'b0;
        check_reset_state("midrst");
        op(0, 1, 8'h3C, 0);
        check("post_rst_count", 32'(bus.count), 1);
        op(1, 0, 8'h00, 0);
        check("post_rst_data", 32'(bus.rd_data), 32'h3C);

        // Full with both requests: read only, overflow set.
        for (int i = 0; i < 16; i++) op(0, 1, 8'(8'h40 + i), 0);
        op(0, 0, 8'h99, 0);
        check("full_both_count", 32'(bus.count), 15);
        check("full_both_data", 32'(bus.rd_data), 32'h40);
        check("full_both_ovf", 32'(bus.overflow), 1);
        check("full_both_not_full", 32'(bus.not_full), 1);
`else
        op(0, 1, 8'h77, 0);
        check("fwft_e1_count", 32'(bus.count), 1);
        check("fwft_e1_not_empty", 32'(bus.not_empty), 0);
        op(1, 1, 8'h00, 0);
        check("fwft_e2_not_empty", 32'(bus.not_empty), 0);
        op(1, 1, 8'h00, 0);
        check("fwft_e3_not_empty", 32'(bus.not_empty), 1);
        check("fwft_e3_rd_data", 32'(bus.rd_data), 32'h77);
        op(1, 0, 8'h00, 0);
        check("fwft_pop_not_empty", 32'(bus.not_empty), 0);
        check("fwft_pop_count", 32'(bus.count), 0);
        check("fwft_pop_rd_data_hold", 32'(bus.rd_data), 32'h77);
        op(1, 0, 8'h00, 0);
        check("fwft_unf", 32'(bus.underflow), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
